// File: rtl/memory_cycle.sv
// -----------------------------------------------------------------------------
// memory_cycle
//
// Memory stage of a five-stage RISC-V style pipeline. It holds the data memory
// and the MEM/WB pipeline register.
//
// The memory is byte-lane organised. It is read combinationally from the word
// addressed by ALU_ResultM, and written on the rising clock edge. Loads are
// extracted and sign- or zero-extended before they are captured into the
// MEM/WB register. Misaligned accesses are flagged. A misaligned access never
// writes memory, and a misaligned load returns zero.
//
// Parameters
//   DMEM_WORDS   data memory depth in 32-bit words (power of two, >= 2)
//
// Ports
//   clk          stage clock, rising edge
//   rst          asynchronous active-high reset of the MEM/WB register
//   RegWriteM    register-file write enable of the instruction in M
//   MemWriteM    store request
//   ResultSrcM   writeback source: 0 = ALU result, 1 = load data
//   Funct3M      access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   RDM          destination register index
//   PCPlus4M     return address
//   ALU_ResultM  effective address / ALU result
//   WriteDataM   store data
//   StallW       hold the MEM/WB register (also holds back a store)
//   FlushW       load a bubble into MEM/WB; has priority over StallW
//   RegWriteW, ResultSrcW, RDW, PCPlus4W, ALU_ResultW, ReadDataW
//                registered copies for the writeback stage
//   MisalignW    the instruction now in writeback made a misaligned access
// -----------------------------------------------------------------------------
module memory_cycle #(
   parameter int DMEM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWriteM,
   input  logic        MemWriteM,
   input  logic        ResultSrcM,
   input  logic [2:0]  Funct3M,
   input  logic [4:0]  RDM,
   input  logic [31:0] PCPlus4M,
   input  logic [31:0] ALU_ResultM,
   input  logic [31:0] WriteDataM,
   input  logic        StallW,
   input  logic        FlushW,
   output logic        RegWriteW,
   output logic        ResultSrcW,
   output logic [4:0]  RDW,
   output logic [31:0] PCPlus4W,
   output logic [31:0] ALU_ResultW,
   output logic [31:0] ReadDataW,
   output logic        MisalignW
);

   localparam int IDX_W = $clog2(DMEM_WORDS);

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_e;

   typedef struct packed {
      logic        reg_write;
      logic        result_src;
      logic [4:0]  rd;
      logic [31:0] pc_plus4;
      logic [31:0] alu_result;
      logic [31:0] read_data;
      logic        misalign;
   } mw_t;

   // ---------------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------------
   // Address bits above the memory size are ignored, so addresses wrap.
   logic [IDX_W-1:0] word_idx;
   logic [1:0]       byte_off;
   size_e            acc_size;
   logic             ld_unsigned;
   logic             misalign_raw;
   logic             misalign_m;

   assign word_idx    = ALU_ResultM[IDX_W+1:2];
   assign byte_off    = ALU_ResultM[1:0];
   assign ld_unsigned = Funct3M[2];

   // Funct3[1:0] = 11 (codes 011 and 111) and code 110 decode as a word access.
   always_comb begin
      acc_size = SZ_WORD;
      case (Funct3M[1:0])
         2'b00:   acc_size = SZ_BYTE;
         2'b01:   acc_size = SZ_HALF;
         default: acc_size = SZ_WORD;
      endcase
   end

   always_comb begin
      misalign_raw = 1'b0;
      case (acc_size)
         SZ_HALF: misalign_raw = byte_off[0];
         SZ_WORD: misalign_raw = |byte_off;
         default: misalign_raw = 1'b0;
      endcase
   end

   // Only memory instructions can be misaligned. An ALU result that happens to
   // look like an odd address must not raise the flag.
   assign misalign_m = (MemWriteM | ResultSrcM) & misalign_raw;

   // ---------------------------------------------------------------------------
   // Store lane enables and lane data
   // ---------------------------------------------------------------------------
   logic        store_ok;
   logic [3:0]  lane_we;
   logic [31:0] wdata_lanes;

   // A held (stalled) store is written once, when the stall releases.
   // A flushed store is a bubble and never writes.
   assign store_ok = MemWriteM & ~StallW & ~FlushW & ~misalign_m;

   // Narrow store data is replicated across the word, so each lane picks up
   // the right bytes by position. The enables then select which lanes are
   // actually written.
   always_comb begin
      lane_we     = 4'b0000;
      wdata_lanes = WriteDataM;
      case (acc_size)
         SZ_BYTE: begin
            lane_we     = 4'b0001 << byte_off;
            wdata_lanes = {4{WriteDataM[7:0]}};
         end
         SZ_HALF: begin
            lane_we     = byte_off[1] ? 4'b1100 : 4'b0011;
            wdata_lanes = {2{WriteDataM[15:0]}};
         end
         default: begin
            lane_we     = 4'b1111;
            wdata_lanes = WriteDataM;
         end
      endcase
      if (!store_ok) begin
         lane_we = 4'b0000;
      end
   end

   // ---------------------------------------------------------------------------
   // Data memory: one byte-wide array per lane, combinational read
   // ---------------------------------------------------------------------------
   logic [31:0] rd_word;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_mem [DMEM_WORDS] = '{default: 8'h00};

         // Reset does not clear memory contents. It only blocks a store that
         // would otherwise land on an edge while reset is high.
         always_ff @(posedge clk) begin
            if (!rst && lane_we[gi]) begin
               lane_mem[word_idx] <= wdata_lanes[gi*8 +: 8];
            end
         end

         assign rd_word[gi*8 +: 8] = lane_mem[word_idx];
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // Load extraction and extension
   // ---------------------------------------------------------------------------
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;
   logic [31:0] read_data_m;

   always_comb begin
      ld_byte = rd_word[{byte_off, 3'b000} +: 8];
      ld_half = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
      ld_data = rd_word;
      case (acc_size)
         SZ_BYTE: ld_data = ld_unsigned ? {24'h000000, ld_byte}
                                        : {{24{ld_byte[7]}}, ld_byte};
         SZ_HALF: ld_data = ld_unsigned ? {16'h0000, ld_half}
                                        : {{16{ld_half[15]}}, ld_half};
         default: ld_data = rd_word;
      endcase
   end

   assign read_data_m = misalign_m ? 32'h0000_0000 : ld_data;

   // ---------------------------------------------------------------------------
   // MEM/WB pipeline register
   // ---------------------------------------------------------------------------
   mw_t mw_q, mw_d;

   always_comb begin
      mw_d = mw_q;
      if (FlushW) begin
         mw_d = '0;
      end else if (!StallW) begin
         mw_d.reg_write  = RegWriteM;
         mw_d.result_src = ResultSrcM;
         mw_d.rd         = RDM;
         mw_d.pc_plus4   = PCPlus4M;
         mw_d.alu_result = ALU_ResultM;
         mw_d.read_data  = read_data_m;
         mw_d.misalign   = misalign_m;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mw_q <= '0;
      end else begin
         mw_q <= mw_d;
      end
   end

   assign RegWriteW   = mw_q.reg_write;
   assign ResultSrcW  = mw_q.result_src;
   assign RDW         = mw_q.rd;
   assign PCPlus4W    = mw_q.pc_plus4;
   assign ALU_ResultW = mw_q.alu_result;
   assign ReadDataW   = mw_q.read_data;
   assign MisalignW   = mw_q.misalign;

endmodule
